// File: rtl/ringnet_if.sv
// Host-side bundle for ringnet: per-station TX/RX valid/ready channels and status pulses.
interface ringnet_if #(
    parameter int N     = 8,
    parameter int ABITS = 3,
    parameter int DW    = 8
);
    logic [N-1:0]       tx_valid;
    logic [N-1:0]       tx_ready;
    logic [N-1:0]       tx_bcast;
    logic [N*ABITS-1:0] tx_dst;
    logic [N*DW-1:0]    tx_data;
    logic [N-1:0]       rx_valid;
    logic [N-1:0]       rx_ready;
    logic [N*ABITS-1:0] rx_src;
    logic [N-1:0]       rx_bcast;
    logic [N*DW-1:0]    rx_data;
    logic [N-1:0]       tx_fail;
    logic [N-1:0]       rx_drop;

    modport master (
        output tx_valid, tx_bcast, tx_dst, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_src, rx_bcast, rx_data, tx_fail, rx_drop
    );

    modport slave (
        input  tx_valid, tx_bcast, tx_dst, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_src, rx_bcast, rx_data, tx_fail, rx_drop
    );
endinterface

// File: rtl/ringnet.sv
// N-station slotted ring: one registered slot per station, per-station TX/RX FIFOs,
// source removal of returning packets, undelivered-unicast and missed-broadcast pulses.
module ringnet #(
    parameter int N     = 8,
    parameter int ABITS = 3,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    ringnet_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             valid;
        logic             bcast;
        logic [ABITS-1:0] dst;
        logic [ABITS-1:0] src;
        logic [DW-1:0]    data;
    } slot_t;

    typedef struct packed {
        logic             bcast;
        logic [ABITS-1:0] dst;
        logic [DW-1:0]    data;
    } txe_t;

    typedef struct packed {
        logic             bcast;
        logic [ABITS-1:0] src;
        logic [DW-1:0]    data;
    } rxe_t;

    slot_t         slot_q   [N];
    slot_t         slot_d   [N];
    slot_t         in_s     [N];
    txe_t          tx_mem_q [N][DEPTH];
    rxe_t          rx_mem_q [N][DEPTH];
    rxe_t          rx_wdata [N];
    logic [PW-1:0] tx_wp_q [N], tx_wp_d [N], tx_rp_q [N], tx_rp_d [N];
    logic [PW-1:0] rx_wp_q [N], rx_wp_d [N], rx_rp_q [N], rx_rp_d [N];
    logic [CW-1:0] tx_cnt_q [N], tx_cnt_d [N], rx_cnt_q [N], rx_cnt_d [N];
    logic [N-1:0]  tx_push, tx_pop, rx_push, rx_pop, free, rx_full;

    always_comb begin
        tx_push      = '0;
        tx_pop       = '0;
        rx_push      = '0;
        rx_pop       = '0;
        free         = '0;
        rx_full      = '0;
        bus.tx_fail  = '0;
        bus.rx_drop  = '0;
        bus.tx_ready = '0;
        bus.rx_valid = '0;
        bus.rx_src   = '0;
        bus.rx_bcast = '0;
        bus.rx_data  = '0;
        for (int i = 0; i < N; i++) begin
            in_s[i]     = slot_q[(i + N - 1) % N];
            rx_full[i]  = (rx_cnt_q[i] == CW'(DEPTH));
            free[i]     = 1'b1;
            slot_d[i]   = '0;
            rx_wdata[i] = '{bcast: in_s[i].bcast, src: in_s[i].src, data: in_s[i].data};

            // Incoming-slot decision: source removal beats delivery, a blocked unicast keeps circulating.
            if (in_s[i].valid) begin
                if (in_s[i].src == ABITS'(i)) begin
                    bus.tx_fail[i] = ~in_s[i].bcast;
                end else if (in_s[i].bcast) begin
                    free[i]        = 1'b0;
                    slot_d[i]      = in_s[i];
                    rx_push[i]     = ~rx_full[i];
                    bus.rx_drop[i] = rx_full[i];
                end else if (in_s[i].dst == ABITS'(i) && !rx_full[i]) begin
                    rx_push[i] = 1'b1;
                end else begin
                    free[i]   = 1'b0;
                    slot_d[i] = in_s[i];
                end
            end

            tx_pop[i] = free[i] && (tx_cnt_q[i] != '0);
            if (tx_pop[i]) begin
                slot_d[i] = '{valid: 1'b1,
                              bcast: tx_mem_q[i][tx_rp_q[i]].bcast,
                              dst:   tx_mem_q[i][tx_rp_q[i]].dst,
                              src:   ABITS'(i),
                              data:  tx_mem_q[i][tx_rp_q[i]].data};
            end

            bus.tx_ready[i] = (tx_cnt_q[i] != CW'(DEPTH));
            bus.rx_valid[i] = (rx_cnt_q[i] != '0);
            tx_push[i]      = bus.tx_valid[i] && bus.tx_ready[i];
            rx_pop[i]       = bus.rx_valid[i] && bus.rx_ready[i];

            bus.rx_src[i*ABITS +: ABITS] = rx_mem_q[i][rx_rp_q[i]].src;
            bus.rx_bcast[i]              = rx_mem_q[i][rx_rp_q[i]].bcast;
            bus.rx_data[i*DW +: DW]      = rx_mem_q[i][rx_rp_q[i]].data;

            tx_wp_d[i]  = tx_wp_q[i] + PW'(tx_push[i]);
            tx_rp_d[i]  = tx_rp_q[i] + PW'(tx_pop[i]);
            tx_cnt_d[i] = tx_cnt_q[i] + CW'(tx_push[i]) - CW'(tx_pop[i]);
            rx_wp_d[i]  = rx_wp_q[i] + PW'(rx_push[i]);
            rx_rp_d[i]  = rx_rp_q[i] + PW'(rx_pop[i]);
            rx_cnt_d[i] = rx_cnt_q[i] + CW'(rx_push[i]) - CW'(rx_pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (tx_push[i]) begin
                tx_mem_q[i][tx_wp_q[i]] <= '{bcast: bus.tx_bcast[i],
                                             dst:   bus.tx_dst[i*ABITS +: ABITS],
                                             data:  bus.tx_data[i*DW +: DW]};
            end
            if (rx_push[i]) begin
                rx_mem_q[i][rx_wp_q[i]] <= rx_wdata[i];
            end
            // Only valid bits and FIFO bookkeeping are cleared; payload storage is left as is.
            if (rst) begin
                slot_q[i].valid <= 1'b0;
                tx_wp_q[i]      <= '0;
                tx_rp_q[i]      <= '0;
                tx_cnt_q[i]     <= '0;
                rx_wp_q[i]      <= '0;
                rx_rp_q[i]      <= '0;
                rx_cnt_q[i]     <= '0;
            end else begin
                slot_q[i]   <= slot_d[i];
                tx_wp_q[i]  <= tx_wp_d[i];
                tx_rp_q[i]  <= tx_rp_d[i];
                tx_cnt_q[i] <= tx_cnt_d[i];
                rx_wp_q[i]  <= rx_wp_d[i];
                rx_rp_q[i]  <= rx_rp_d[i];
                rx_cnt_q[i] <= rx_cnt_d[i];
            end
        end
    end
endmodule
